// File: rtl/zmod_link_checker.sv
// rtl/zmod_link_checker.sv - framed counter-stream link checker with lock FSM and saturating statistics
// Optional first-error capture ports are built when ZMOD_CHK_CAPTURE_EN is defined.
module zmod_link_checker #(
    parameter logic [7:0] MARKER     = 8'h01,
    parameter int         LOCK_GOOD  = 8,
    parameter int         UNLOCK_BAD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    input  logic        clear,
    output logic        locked,
    output logic [31:0] word_count,
    output logic [31:0] err_count,
    output logic [15:0] loss_count
`ifdef ZMOD_CHK_CAPTURE_EN
    ,
    output logic [31:0] first_bad_rx,
    output logic [23:0] first_bad_exp,
    output logic        capture_valid
`endif
);

    localparam logic [7:0] LOCK_GOOD_C  = 8'(LOCK_GOOD);
    localparam logic [7:0] UNLOCK_BAD_C = 8'(UNLOCK_BAD);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] expected_q, expected_d;
    logic [7:0]  good_run_q, good_run_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic [15:0] loss_count_q, loss_count_d;

    logic        marker_ok;
    logic        word_good;
    logic [23:0] payload_next;
    logic [7:0]  good_run_inc;
    logic [7:0]  bad_run_inc;
    logic        word_inc;
    logic        err_inc;
    logic        loss_inc;

`ifdef ZMOD_CHK_CAPTURE_EN
    logic [31:0] first_bad_rx_q, first_bad_rx_d;
    logic [23:0] first_bad_exp_q, first_bad_exp_d;
    logic        capture_valid_q, capture_valid_d;
`endif

    assign marker_ok    = (rx_data[31:24] == MARKER);
    assign word_good    = marker_ok && (rx_data[23:0] == expected_q);
    assign payload_next = rx_data[23:0] + 24'd1;
    assign good_run_inc = good_run_q + 8'd1;
    assign bad_run_inc  = bad_run_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            expected_q   <= 24'd0;
            good_run_q   <= 8'd0;
            bad_run_q    <= 8'd0;
            word_count_q <= 32'd0;
            err_count_q  <= 32'd0;
            loss_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            loss_count_q <= loss_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (marker_ok) state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (word_good) begin
                        if (good_run_inc == LOCK_GOOD_C) state_d = ST_LOCKED;
                    end else if (!marker_ok) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (!word_good && (bad_run_inc == UNLOCK_BAD_C)) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Run lengths, expected value and event strobes for the counters.
    always_comb begin
        expected_d = expected_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        word_inc   = 1'b0;
        err_inc    = 1'b0;
        loss_inc   = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (marker_ok) begin
                        expected_d = payload_next;
                        good_run_d = 8'd1;
                        bad_run_d  = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    if (word_good) begin
                        expected_d = expected_q + 24'd1;
                        good_run_d = good_run_inc;
                        bad_run_d  = 8'd0;
                    end else if (marker_ok) begin
                        expected_d = payload_next;
                        good_run_d = 8'd1;
                    end else begin
                        good_run_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Expected free-runs while locked so single corrupt words never realign.
                    expected_d = expected_q + 24'd1;
                    word_inc   = 1'b1;
                    if (word_good) begin
                        bad_run_d = 8'd0;
                    end else begin
                        err_inc = 1'b1;
                        if (bad_run_inc == UNLOCK_BAD_C) begin
                            loss_inc   = 1'b1;
                            good_run_d = 8'd0;
                            bad_run_d  = 8'd0;
                        end else begin
                            bad_run_d = bad_run_inc;
                        end
                    end
                end
                default: begin
                    good_run_d = 8'd0;
                    bad_run_d  = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        loss_count_d = loss_count_q;
        if (clear) begin
            word_count_d = 32'd0;
            err_count_d  = 32'd0;
            loss_count_d = 16'd0;
        end else begin
            if (word_inc && (word_count_q != 32'hFFFF_FFFF)) word_count_d = word_count_q + 32'd1;
            if (err_inc && (err_count_q != 32'hFFFF_FFFF))   err_count_d  = err_count_q + 32'd1;
            if (loss_inc && (loss_count_q != 16'hFFFF))      loss_count_d = loss_count_q + 16'd1;
        end
    end

    assign word_count = word_count_q;
    assign err_count  = err_count_q;
    assign loss_count = loss_count_q;

`ifdef ZMOD_CHK_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_bad_rx_q  <= 32'd0;
            first_bad_exp_q <= 24'd0;
            capture_valid_q <= 1'b0;
        end else begin
            first_bad_rx_q  <= first_bad_rx_d;
            first_bad_exp_q <= first_bad_exp_d;
            capture_valid_q <= capture_valid_d;
        end
    end

    always_comb begin
        first_bad_rx_d  = first_bad_rx_q;
        first_bad_exp_d = first_bad_exp_q;
        capture_valid_d = capture_valid_q;
        if (clear) begin
            capture_valid_d = 1'b0;
        end else if (err_inc && !capture_valid_q) begin
            first_bad_rx_d  = rx_data;
            first_bad_exp_d = expected_q;
            capture_valid_d = 1'b1;
        end
    end

    assign first_bad_rx  = first_bad_rx_q;
    assign first_bad_exp = first_bad_exp_q;
    assign capture_valid = capture_valid_q;
`endif

endmodule

// File: tb/tb_zmod_link_checker.sv
// tb/tb_zmod_link_checker.sv - self-checking bench for zmod_link_checker against a behavioural model
module tb_zmod_link_checker;

    localparam int LOCK_GOOD  = 8;
    localparam int UNLOCK_BAD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        rx_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic [31:0] word_count;
    logic [31:0] err_count;
    logic [15:0] loss_count;
`ifdef ZMOD_CHK_CAPTURE_EN
    logic [31:0] first_bad_rx;
    logic [23:0] first_bad_exp;
    logic        capture_valid;
`endif

    zmod_link_checker #(.MARKER(8'h01), .LOCK_GOOD(LOCK_GOOD), .UNLOCK_BAD(UNLOCK_BAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .clear      (clear),
        .locked     (locked),
        .word_count (word_count),
        .err_count  (err_count),
        .loss_count (loss_count)
`ifdef ZMOD_CHK_CAPTURE_EN
        ,
        .first_bad_rx  (first_bad_rx),
        .first_bad_exp (first_bad_exp),
        .capture_valid (capture_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] seq;

    // Reference model: link is hunting, verifying a candidate alignment, or locked.
    int          m_mode;
    logic [23:0] m_exp;
    int          m_good, m_bad;
    longint      m_wc, m_ec, m_lc;
    logic [31:0] m_cap_rx;
    logic [23:0] m_cap_exp;
    bit          m_cap_v;

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
        m_wc = 0; m_ec = 0; m_lc = 0;
        m_cap_rx = 0; m_cap_exp = 0; m_cap_v = 0;
    endtask

    task automatic model_update(input logic [31:0] d, input bit v, input bit c);
        bit mk, good;
        if (v) begin
            mk   = (d[31:24] == 8'h01);
            good = mk && (d[23:0] == m_exp);
            if (m_mode == 0) begin
                if (mk) begin m_exp = d[23:0] + 24'd1; m_good = 1; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (good) begin
                    m_exp = m_exp + 24'd1; m_good++;
                    if (m_good == LOCK_GOOD) begin m_mode = 2; m_bad = 0; end
                end else if (mk) begin
                    m_exp = d[23:0] + 24'd1; m_good = 1;
                end else begin
                    m_mode = 0; m_good = 0;
                end
            end else begin
                m_wc = (m_wc < 64'hFFFF_FFFF) ? m_wc + 1 : m_wc;
                if (good) m_bad = 0;
                else begin
                    m_ec = (m_ec < 64'hFFFF_FFFF) ? m_ec + 1 : m_ec;
                    if (!m_cap_v && !c) begin m_cap_rx = d; m_cap_exp = m_exp; m_cap_v = 1; end
                    m_bad++;
                    if (m_bad == UNLOCK_BAD) begin
                        m_mode = 0; m_bad = 0; m_good = 0;
                        m_lc = (m_lc < 65535) ? m_lc + 1 : m_lc;
                    end
                end
                m_exp = m_exp + 24'd1;
            end
        end
        if (c) begin m_wc = 0; m_ec = 0; m_lc = 0; m_cap_v = 0; end
    endtask

    // Drives one cycle from a negedge, updates the model at the edge, returns at the next negedge.
    task automatic cycle(input logic [31:0] d, input bit v, input bit c);
        rx_data = d; rx_valid = v; clear = c;
        @(posedge clk);
        model_update(d, v, c);
        @(negedge clk);
        rx_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic good_word();
        cycle({8'h01, seq}, 1'b1, 1'b0);
        seq = seq + 24'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        if (word_count !== 32'd0) begin n_errors++; $display("FAIL reset_word_count: got %0h expected 0", word_count); end
        if (err_count !== 32'd0) begin n_errors++; $display("FAIL reset_err_count: got %0h expected 0", err_count); end
        if (loss_count !== 16'd0) begin n_errors++; $display("FAIL reset_loss_count: got %0h expected 0", loss_count); end
    endtask

    task automatic test_lock();
        seq = 24'h000000;
        for (int i = 0; i < 8; i++) begin
            good_word();
            n_checks++;
            if (locked !== (i == 7)) begin n_errors++; $display("FAIL lock_word%0d: got %0b expected %0b", i, locked, (i == 7)); end
        end
        n_checks += 2;
        if (err_count !== 32'd0) begin n_errors++; $display("FAIL lock_err_count: got %0h expected 0", err_count); end
        if (word_count !== 32'd0) begin n_errors++; $display("FAIL lock_word_count: got %0h expected 0", word_count); end
    endtask

    task automatic test_loss();
        logic [31:0] e0;
        e0 = err_count;
        for (int i = 0; i < 4; i++) begin
            cycle({8'h02, seq}, 1'b1, 1'b0);
            seq = seq + 24'd1;
            n_checks++;
            if (locked !== (i < 3)) begin n_errors++; $display("FAIL loss_bad%0d_locked: got %0b expected %0b", i, locked, (i < 3)); end
        end
        n_checks += 2;
        if (loss_count !== 16'd1) begin n_errors++; $display("FAIL loss_count: got %0h expected 1", loss_count); end
        if (err_count !== e0 + 32'd4) begin n_errors++; $display("FAIL loss_err_count: got %0h expected %0h", err_count, e0 + 32'd4); end
        seq = 24'h123440;
        for (int i = 0; i < 8; i++) begin
            good_word();
            n_checks++;
            if (locked !== (i == 7)) begin n_errors++; $display("FAIL relock_word%0d: got %0b expected %0b", i, locked, (i == 7)); end
        end
    endtask

    task automatic test_single_error();
        logic [31:0] e0, w0;
        while (seq != 24'h123456) good_word();
        e0 = err_count; w0 = word_count;
        cycle(32'h01123457, 1'b1, 1'b0);
        seq = seq + 24'd1;
        n_checks += 2;
        if (err_count !== e0 + 32'd1) begin n_errors++; $display("FAIL single_err_count: got %0h expected %0h", err_count, e0 + 32'd1); end
        if (locked !== 1'b1) begin n_errors++; $display("FAIL single_err_locked: got %0b expected 1", locked); end
        good_word();
        n_checks += 2;
        if (err_count !== e0 + 32'd1) begin n_errors++; $display("FAIL single_next_good: got %0h expected %0h", err_count, e0 + 32'd1); end
        if (word_count !== w0 + 32'd2) begin n_errors++; $display("FAIL single_word_count: got %0h expected %0h", word_count, w0 + 32'd2); end
    endtask

    task automatic test_wrap();
        logic [31:0] e0;
        for (int i = 0; i < 4; i++) cycle({8'h02, seq}, 1'b1, 1'b0);
        seq = 24'hFFFFF0;
        repeat (8) good_word();
        e0 = err_count;
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL wrap_prelock: got %0b expected 1", locked); end
        for (int i = 0; i < 12; i++) begin
            good_word();
            n_checks++;
            if (locked !== 1'b1) begin n_errors++; $display("FAIL wrap_locked%0d: got %0b expected 1", i, locked); end
        end
        n_checks++;
        if (err_count !== e0) begin n_errors++; $display("FAIL wrap_err_count: got %0h expected %0h", err_count, e0); end
    endtask

    task automatic test_clear();
        cycle({8'h01, seq ^ 24'h000100}, 1'b1, 1'b1);
        seq = seq + 24'd1;
        n_checks += 4;
        if (err_count !== 32'd0) begin n_errors++; $display("FAIL clear_err_count: got %0h expected 0", err_count); end
        if (word_count !== 32'd0) begin n_errors++; $display("FAIL clear_word_count: got %0h expected 0", word_count); end
        if (loss_count !== 16'd0) begin n_errors++; $display("FAIL clear_loss_count: got %0h expected 0", loss_count); end
        if (locked !== 1'b1) begin n_errors++; $display("FAIL clear_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_valid_toggle();
        logic [31:0] w0;
        w0 = word_count;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) good_word();
            else cycle($urandom, 1'b0, 1'b0);
            n_checks++;
            if (word_count !== w0 + 32'(i / 2 + 1)) begin
                n_errors++; $display("FAIL toggle_word_count%0d: got %0h expected %0h", i, word_count, w0 + 32'(i / 2 + 1));
            end
        end
        n_checks++;
        if (err_count !== 32'd0) begin n_errors++; $display("FAIL toggle_err_count: got %0h expected 0", err_count); end
    endtask

    task automatic test_random();
        int r;
        bit v, c;
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            if (r < 78)      d = {8'h01, seq};
            else if (r < 88) d = {8'h01, seq ^ (24'd1 << $urandom_range(0, 23))};
            else if (r < 96) d = {8'($urandom_range(2, 255)), seq};
            else begin seq = seq + 24'($urandom_range(2, 40)); d = {8'h01, seq}; end
            cycle(d, v, c);
            if (v) seq = seq + 24'd1;
            n_checks += 4;
            if (locked !== (m_mode == 2)) begin n_errors++; $display("FAIL rand_locked@%0d: got %0b expected %0b", i, locked, (m_mode == 2)); end
            if (word_count !== 32'(m_wc)) begin n_errors++; $display("FAIL rand_word_count@%0d: got %0h expected %0h", i, word_count, m_wc); end
            if (err_count !== 32'(m_ec)) begin n_errors++; $display("FAIL rand_err_count@%0d: got %0h expected %0h", i, err_count, m_ec); end
            if (loss_count !== 16'(m_lc)) begin n_errors++; $display("FAIL rand_loss_count@%0d: got %0h expected %0h", i, loss_count, m_lc); end
`ifdef ZMOD_CHK_CAPTURE_EN
            n_checks++;
            if (capture_valid !== m_cap_v || (m_cap_v && (first_bad_rx !== m_cap_rx || first_bad_exp !== m_cap_exp))) begin
                n_errors++; $display("FAIL rand_capture@%0d: got %0b/%0h/%0h expected %0b/%0h/%0h", i,
                                     capture_valid, first_bad_rx, first_bad_exp, m_cap_v, m_cap_rx, m_cap_exp);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        repeat (14) good_word();
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL areset_prelock: got %0b expected 1", locked); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL areset_locked: got %0b expected 0", locked); end
        if (word_count !== 32'd0) begin n_errors++; $display("FAIL areset_word_count: got %0h expected 0", word_count); end
        if (err_count !== 32'd0) begin n_errors++; $display("FAIL areset_err_count: got %0h expected 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seq = 24'h000000;
        for (int i = 0; i < 8; i++) begin
            good_word();
            n_checks++;
            if (locked !== (i == 7)) begin n_errors++; $display("FAIL areset_relock%0d: got %0b expected %0b", i, locked, (i == 7)); end
        end
`ifdef ZMOD_CHK_CAPTURE_EN
        while (seq != 24'h000011) good_word();
        cycle(32'h01000010, 1'b1, 1'b0);
        seq = seq + 24'd1;
        n_checks += 3;
        if (first_bad_rx !== 32'h01000010) begin n_errors++; $display("FAIL cap_rx: got %0h expected 01000010", first_bad_rx); end
        if (first_bad_exp !== 24'h000011) begin n_errors++; $display("FAIL cap_exp: got %0h expected 000011", first_bad_exp); end
        if (capture_valid !== 1'b1) begin n_errors++; $display("FAIL cap_valid: got %0b expected 1", capture_valid); end
        cycle(32'h01ABCDEF, 1'b1, 1'b0);
        seq = seq + 24'd1;
        n_checks++;
        if (first_bad_rx !== 32'h01000010) begin n_errors++; $display("FAIL cap_hold: got %0h expected 01000010", first_bad_rx); end
        cycle({8'h01, seq}, 1'b1, 1'b1);
        seq = seq + 24'd1;
        n_checks++;
        if (capture_valid !== 1'b0) begin n_errors++; $display("FAIL cap_rearm: got %0b expected 0", capture_valid); end
`endif
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_lock();
        test_loss();
        test_single_error();
        test_wrap();
        test_clear();
        test_valid_toggle();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
